// File: rtl/native_pkg.sv
// rtl/native_pkg.sv - shared types and defaults for the native port gate
package native_pkg;

    localparam int NATIVE_ADDR_W = 25;
    localparam int NATIVE_DATA_W = 128;

    // One byte-enable bit per data byte.
    function automatic int mask_w(input int data_w);
        return data_w / 8;
    endfunction

    // Native command at the default address width.
    typedef struct packed {
        logic                     we;
        logic                     mw;
        logic [NATIVE_ADDR_W-1:0] addr;
    } cmd_t;

    // Command holding register occupancy.
    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } gate_state_e;

endpackage

// File: rtl/native_sync_fifo.sv
// rtl/native_sync_fifo.sv - synchronous FIFO with count, full and empty
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push, push_data   write side; accepted when not full, or when full and popping
//   pop, pop_data     read side; pop_data is the current head
//   count, full, empty occupancy status
module native_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    localparam logic [AW:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        full    = (count_q == FULL_CNT);
        empty   = (count_q == '0);
        do_pop  = pop & ~empty;
        // A push into a full FIFO is fine when the head leaves in the same cycle.
        do_push = push & (~full | do_pop);

        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);

        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
            end
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/native_port_gate.sv
// rtl/native_port_gate.sv - holds native cmds until the controller can complete them without stalling
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cmd_*                          native command stream in (we, mw, addr)
//   wdata_*                        native write-data stream in (data, byte enables)
//   rdata_*                        native read-return stream out (single beat)
//   ctrl_cmd_*                     controller command out
//   ctrl_wdata_*                   controller write data out
//   ctrl_rdata_valid/data          controller read return in, no backpressure
//   err_rd_unexpected              sticky: read data arrived with nothing outstanding
module native_port_gate
    import native_pkg::*;
#(
    parameter int ADDR_W  = NATIVE_ADDR_W,
    parameter int DATA_W  = NATIVE_DATA_W,
    parameter int WDEPTH  = 8,
    parameter int RDEPTH  = 8,
    localparam int MASK_W = mask_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_payload_we,
    input  logic              cmd_payload_mw,
    input  logic [ADDR_W-1:0] cmd_payload_addr,

    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata_payload_data,
    input  logic [MASK_W-1:0] wdata_payload_we,

    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic              rdata_first,
    output logic              rdata_last,
    output logic [DATA_W-1:0] rdata_payload_data,

    output logic              ctrl_cmd_valid,
    input  logic              ctrl_cmd_ready,
    output logic              ctrl_cmd_we,
    output logic              ctrl_cmd_mw,
    output logic [ADDR_W-1:0] ctrl_cmd_addr,

    output logic              ctrl_wdata_valid,
    input  logic              ctrl_wdata_ready,
    output logic [DATA_W-1:0] ctrl_wdata_data,
    output logic [MASK_W-1:0] ctrl_wdata_we,

    input  logic              ctrl_rdata_valid,
    input  logic [DATA_W-1:0] ctrl_rdata_data,

    output logic              err_rd_unexpected
);

    localparam int WAW = $clog2(WDEPTH);
    localparam int RAW = $clog2(RDEPTH);
    localparam int WCW = WAW + 1;
    localparam int RCW = RAW + 1;
    localparam int RSW = RAW + 2;
    localparam logic [RAW+1:0] RSUM_LIM = RSW'(RDEPTH);

    typedef struct packed {
        logic              we;
        logic              mw;
        logic [ADDR_W-1:0] addr;
    } hold_t;

    gate_state_e state_q, state_d;
    hold_t       hold_q, hold_d;
    logic [WAW:0] claimed_q, claimed_d;
    logic [RAW:0] rd_out_q, rd_out_d;
    logic         err_q, err_d;

    logic [WAW:0]   wcount;
    logic           wfull, wempty;
    logic [RAW:0]   rcount;
    logic           rfull, rempty;
    logic [RAW+1:0] rsum;

    logic cmd_hs, issue, wr_issue, rd_issue;
    logic wgate, rgate;
    logic wdata_push, wdata_pop, rd_push, rd_pop;

    // Handshakes and gate conditions
    always_comb begin
        cmd_hs   = cmd_valid & cmd_ready;
        issue    = ctrl_cmd_valid & ctrl_cmd_ready;
        wr_issue = issue & hold_q.we;
        rd_issue = issue & ~hold_q.we;

        // A write may go only if some buffered beat is not yet owned by an
        // earlier issued write.
        wgate = (wcount > claimed_q);
        // Every outstanding read plus every parked beat needs a return slot.
        rsum  = {1'b0, rd_out_q} + {1'b0, rcount};
        rgate = (rsum < RSUM_LIM);

        wdata_push = wdata_valid & wdata_ready;
        wdata_pop  = ctrl_wdata_valid & ctrl_wdata_ready;
        rd_pop     = rdata_valid & rdata_ready;
        rd_push    = ctrl_rdata_valid & (~rfull | rd_pop);
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // FSM: next state and holding register
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            EMPTY: if (cmd_hs) state_d = HELD;
            HELD:  if (issue && !cmd_hs) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        if (cmd_hs) begin
            hold_d.we   = cmd_payload_we;
            hold_d.mw   = cmd_payload_mw;
            hold_d.addr = cmd_payload_addr;
        end
    end

    // FSM: outputs
    always_comb begin
        ctrl_cmd_valid = (state_q == HELD) & (hold_q.we ? wgate : rgate);
        // Accept a new cmd when the register is free or is being vacated now.
        cmd_ready      = (state_q == EMPTY) |
                         ((state_q == HELD) & ctrl_cmd_valid & ctrl_cmd_ready);
        ctrl_cmd_we    = hold_q.we;
        ctrl_cmd_mw    = hold_q.mw;
        ctrl_cmd_addr  = hold_q.addr;
    end

    // Claim and outstanding-read counters, sticky error
    always_comb begin
        claimed_d = claimed_q;
        case ({wr_issue, wdata_pop})
            2'b10:   claimed_d = claimed_q + WCW'(1);
            2'b01:   claimed_d = claimed_q - WCW'(1);
            default: claimed_d = claimed_q;
        endcase

        rd_out_d = rd_out_q;
        case ({rd_issue, ctrl_rdata_valid})
            2'b10: rd_out_d = rd_out_q + RCW'(1);
            // An unexpected return must not wrap the counter below zero.
            2'b01: if (rd_out_q != '0) rd_out_d = rd_out_q - RCW'(1);
            default: rd_out_d = rd_out_q;
        endcase

        err_d = err_q | (ctrl_rdata_valid & (rd_out_q == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            claimed_q <= '0;
            rd_out_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            claimed_q <= claimed_d;
            rd_out_q  <= rd_out_d;
            err_q     <= err_d;
        end
    end

    // Write data parks here until its cmd has gone to the controller.
    native_sync_fifo #(
        .WIDTH (DATA_W + MASK_W),
        .DEPTH (WDEPTH)
    ) u_wdata_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wdata_push),
        .push_data ({wdata_payload_data, wdata_payload_we}),
        .pop       (wdata_pop),
        .pop_data  ({ctrl_wdata_data, ctrl_wdata_we}),
        .count     (wcount),
        .full      (wfull),
        .empty     (wempty)
    );

    // Read returns land here since the controller cannot be stalled.
    native_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (RDEPTH)
    ) u_rdata_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_push),
        .push_data (ctrl_rdata_data),
        .pop       (rd_pop),
        .pop_data  (rdata_payload_data),
        .count     (rcount),
        .full      (rfull),
        .empty     (rempty)
    );

    always_comb begin
        wdata_ready       = ~wfull;
        // claimed never exceeds the buffered count; the empty term is a guard.
        ctrl_wdata_valid  = (claimed_q != '0) & ~wempty;
        rdata_valid       = ~rempty;
        rdata_first       = 1'b1;
        rdata_last        = 1'b1;
        err_rd_unexpected = err_q;
    end

endmodule
